// File: rtl/vga_timing_pkg.sv
// Raster timing constants and helpers shared by the sync generator and the
// downstream pixel stages. The defaults describe 640x480@60 at 25.175 MHz.
package vga_timing_pkg;

  localparam int POS_W     = 10;
  localparam int MAX_TOTAL = 1 << POS_W;

  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  function automatic int span_total(input int display, input int front,
                                    input int sync, input int back);
    return display + front + sync + back;
  endfunction

  function automatic int sync_first(input int display, input int front);
    return display + front;
  endfunction

  function automatic int sync_last(input int display, input int front, input int sync);
    return display + front + sync - 1;
  endfunction

  function automatic logic in_window(input logic [POS_W-1:0] pos,
                                     input int first, input int last);
    return (int'(pos) >= first) && (int'(pos) <= last);
  endfunction

  localparam int DEF_H_TOTAL      = span_total(DEF_H_DISPLAY, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
  localparam int DEF_V_TOTAL      = span_total(DEF_V_DISPLAY, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);
  localparam int DEF_H_SYNC_FIRST = sync_first(DEF_H_DISPLAY, DEF_H_FRONT);
  localparam int DEF_H_SYNC_LAST  = sync_last(DEF_H_DISPLAY, DEF_H_FRONT, DEF_H_SYNC);
  localparam int DEF_V_SYNC_FIRST = sync_first(DEF_V_DISPLAY, DEF_V_FRONT);
  localparam int DEF_V_SYNC_LAST  = sync_last(DEF_V_DISPLAY, DEF_V_FRONT, DEF_V_SYNC);

endpackage

// File: rtl/wrap_counter.sv
// Enable-driven counter running 0..MAX; wrap flags the increment that
// returns it to zero so a cascaded counter can step on the same edge.
module wrap_counter #(
  parameter int MAX   = 799,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX);

  if (MAX < 1 || MAX >= (1 << WIDTH)) begin : g_range_check
    $error("wrap_counter: MAX=%0d does not fit in %0d bits", MAX, WIDTH);
  end

  logic [WIDTH-1:0] count_next;

  assign wrap = inc && (count == LAST);

  // NOTE: count_next gets a default before any branch, so no latch is inferred.
  always_comb begin
    count_next = count;
    if (clr) begin
      count_next = '0;
    end else if (wrap) begin
      count_next = '0;
    end else if (inc) begin
      count_next = count + WIDTH'(1);
    end
  end

  // NOTE: reset is synchronous, so rst_n stays out of the event list; state
  // uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: position counters plus registered sync,
// active-video and strobe outputs aligned with the position they describe.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY = DEF_H_DISPLAY,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_DISPLAY = DEF_V_DISPLAY,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       line_start,
  output logic       frame_start,
  output logic       vblank_start,
  output logic [9:0] frame_cnt
);

  localparam int H_TOTAL  = span_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL  = span_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
  localparam int HS_FIRST = sync_first(H_DISPLAY, H_FRONT);
  localparam int HS_LAST  = sync_last(H_DISPLAY, H_FRONT, H_SYNC);
  localparam int VS_FIRST = sync_first(V_DISPLAY, V_FRONT);
  localparam int VS_LAST  = sync_last(V_DISPLAY, V_FRONT, V_SYNC);

  localparam logic [POS_W-1:0] VBLANK_LINE = POS_W'(V_DISPLAY);

  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_total_check
    $error("vga_sync_gen: H_TOTAL=%0d / V_TOTAL=%0d exceed %0d", H_TOTAL, V_TOTAL, MAX_TOTAL);
  end

  logic             h_wrap;
  logic             v_wrap;
  logic [POS_W-1:0] h_next;
  logic [POS_W-1:0] v_next;

  wrap_counter #(
    .MAX   (H_TOTAL - 1),
    .WIDTH (POS_W)
  ) u_hcnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (en),
    .clr   (1'b0),
    .count (hpos),
    .wrap  (h_wrap)
  );

  wrap_counter #(
    .MAX   (V_TOTAL - 1),
    .WIDTH (POS_W)
  ) u_vcnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (en & h_wrap),
    .clr   (1'b0),
    .count (vpos),
    .wrap  (v_wrap)
  );

  // Position the counters move to on this edge; decoding it here and
  // registering the result keeps every output aligned with hpos/vpos.
  always_comb begin
    h_next = h_wrap ? '0 : hpos + POS_W'(1);
    v_next = vpos;
    if (v_wrap) begin
      v_next = '0;
    end else if (h_wrap) begin
      v_next = vpos + POS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hsync        <= ~SYNC_POL;
      vsync        <= ~SYNC_POL;
      display_on   <= 1'b0;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      // h_wrap/v_wrap already carry en, so strobes drop on any idle edge.
      line_start   <= h_wrap;
      frame_start  <= v_wrap;
      vblank_start <= h_wrap && (v_next == VBLANK_LINE);
      frame_cnt    <= frame_cnt + POS_W'(v_wrap);
      if (en) begin
        hsync      <= in_window(h_next, HS_FIRST, HS_LAST) ? SYNC_POL : ~SYNC_POL;
        vsync      <= in_window(v_next, VS_FIRST, VS_LAST) ? SYNC_POL : ~SYNC_POL;
        display_on <= (int'(h_next) < H_DISPLAY) && (int'(v_next) < V_DISPLAY);
      end
    end
  end

endmodule
